// File: rtl/cb_pkg.sv
// Shared helpers and legal-range constants for the cascadable counter family
// (up counters and the 8-bit down-counter macros).
package cb_pkg;

    localparam int     CB_WIDTH_MIN   = 2;
    localparam int     CB_WIDTH_MAX   = 32;
    localparam longint CB_MODULUS_MIN = 2;

    // Decoded per-edge action of a counter stage.
    typedef enum logic [2:0] {
        CB_HOLD,
        CB_CLEAR,
        CB_LOAD,
        CB_STEP,
        CB_WRAP,
        CB_DROP
    } cb_action_e;

    function automatic int cb_clog2(input longint value);
        int     bits;
        longint span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            bits = bits + 1;
        end
        return bits;
    endfunction

    function automatic longint cb_modulus_max(input int width);
        return longint'(1) << width;
    endfunction

    // Terminal count MODULUS-1, sized to the widest legal counter.
    function automatic logic [CB_WIDTH_MAX-1:0] cb_terminal(input longint modulus);
        logic [63:0] term;
        term = modulus - 64'd1;
        return term[CB_WIDTH_MAX-1:0];
    endfunction

endpackage

// File: rtl/cbu_mod_counter_if.sv
// Count/load/clear controls and count/carry outputs of one cbu_mod_counter stage.
interface cbu_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             CAI;
    logic             SCLR;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             CAO;
    logic             TCQ;

    modport master (
        output CAI, SCLR, LD, D,
        input  Q, CAO, TCQ
    );

    modport slave (
        input  CAI, SCLR, LD, D,
        output Q, CAO, TCQ
    );
endinterface

// File: rtl/cbu_mod_counter.sv
// Cascadable modulo-N up counter with synchronous clear/load, combinational
// carry-out and a registered terminal-count strobe.
module cbu_mod_counter
    import cb_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256
) (
    input logic             CLK,
    input logic             CDN,
    cbu_mod_counter_if.slave bus
);

    if (WIDTH < CB_WIDTH_MIN || WIDTH > CB_WIDTH_MAX ||
        MODULUS < CB_MODULUS_MIN || MODULUS > cb_modulus_max(WIDTH)) begin : g_param_check
        $error("cbu_mod_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] TERM = WIDTH'(cb_terminal(MODULUS));

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             tcq_r;
    logic             tcq_nxt;
    logic             at_term;
    logic             past_term;
    cb_action_e       action;

    assign at_term   = (q_r == TERM);
    // Only reachable after an out-of-range load; the next count drops to 0 silently.
    assign past_term = (q_r > TERM);

    always_comb begin
        action = CB_HOLD;
        if (bus.SCLR) begin
            action = CB_CLEAR;
        end else if (bus.LD) begin
            action = CB_LOAD;
        end else if (bus.CAI) begin
            if (at_term) begin
                action = CB_WRAP;
            end else if (past_term) begin
                action = CB_DROP;
            end else begin
                action = CB_STEP;
            end
        end
    end

    always_comb begin
        q_nxt   = q_r;
        tcq_nxt = 1'b0;
        unique case (action)
            CB_CLEAR: q_nxt = '0;
            CB_LOAD:  q_nxt = bus.D;
            CB_STEP:  q_nxt = q_r + WIDTH'(1);
            CB_WRAP: begin
                q_nxt   = '0;
                tcq_nxt = 1'b1;
            end
            CB_DROP:  q_nxt = '0;
            default:  q_nxt = q_r;
        endcase
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            q_r   <= '0;
            tcq_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            tcq_r <= tcq_nxt;
        end
    end

    assign bus.Q   = q_r;
    assign bus.CAO = bus.CAI && at_term;
    assign bus.TCQ = tcq_r;

endmodule

// File: tb/tb_cbu_mod_counter.sv
// Bench for cbu_mod_counter: directed reset/wrap/priority/load cases, a random
// run against an arithmetic reference, and a two-stage cascade.
module tb_cbu_mod_counter;

    logic CLK = 1'b0;
    logic CDN;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    cbu_mod_counter_if #(.WIDTH(8)) b8();
    cbu_mod_counter_if #(.WIDTH(4)) b10();
    cbu_mod_counter_if #(.WIDTH(8)) blo();
    cbu_mod_counter_if #(.WIDTH(8)) bhi();

    cbu_mod_counter #(.WIDTH(8), .MODULUS(256)) u8  (.CLK(CLK), .CDN(CDN), .bus(b8.slave));
    cbu_mod_counter #(.WIDTH(4), .MODULUS(10))  u10 (.CLK(CLK), .CDN(CDN), .bus(b10.slave));
    cbu_mod_counter #(.WIDTH(8), .MODULUS(256)) ulo (.CLK(CLK), .CDN(CDN), .bus(blo.slave));
    cbu_mod_counter #(.WIDTH(8), .MODULUS(256)) uhi (.CLK(CLK), .CDN(CDN), .bus(bhi.slave));

    assign bhi.CAI = blo.CAO;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: next count and strobe from the counting rules, as plain integers.
    function automatic void ref_next(input int q, input int modulus, input bit sclr,
                                     input bit ld, input bit cai, input int d,
                                     output int q_n, output int tcq_n);
        tcq_n = 0;
        q_n   = q;
        if (sclr)          q_n = 0;
        else if (ld)       q_n = d;
        else if (cai) begin
            if (q == modulus - 1) begin
                q_n   = 0;
                tcq_n = 1;
            end else if (q > modulus - 1) begin
                q_n = 0;
            end else begin
                q_n = q + 1;
            end
        end
    endfunction

    initial begin
        int  mq;
        int  mq_n;
        int  mtcq;
        int  pulses;
        int  rd;
        bit  rs;
        bit  rl;
        bit  rc;

        CDN      = 1'b0;
        b8.CAI   = 1'b0; b8.SCLR  = 1'b0; b8.LD  = 1'b0; b8.D  = '0;
        b10.CAI  = 1'b0; b10.SCLR = 1'b0; b10.LD = 1'b0; b10.D = '0;
        blo.CAI  = 1'b0; blo.SCLR = 1'b0; blo.LD = 1'b0; blo.D = '0;
        bhi.SCLR = 1'b0; bhi.LD   = 1'b0; bhi.D  = '0;
        #1;
        chk("reset_q",   32'(b8.Q),   32'h0);
        chk("reset_tcq", 32'(b8.TCQ), 32'h0);
        chk("reset_cao", 32'(b8.CAO), 32'h0);
        #10;
        CDN = 1'b1;

        // Asynchronous clear from a loaded value, no clock edge involved.
        b8.LD = 1'b1; b8.D = 8'h5A;
        step();
        b8.LD = 1'b0;
        chk("load_5a", 32'(b8.Q), 32'h5A);
        #2;
        CDN = 1'b0;
        #1;
        chk("async_q",   32'(b8.Q),   32'h0);
        chk("async_tcq", 32'(b8.TCQ), 32'h0);
        chk("async_cao", 32'(b8.CAO), 32'h0);
        #1;
        CDN = 1'b1;
        b8.CAI = 1'b1;
        step(); step(); step();
        chk("count_3", 32'(b8.Q), 32'h3);

        // Natural wrap at 2**WIDTH.
        b8.CAI = 1'b0; b8.LD = 1'b1; b8.D = 8'hFE;
        step();
        b8.LD = 1'b0; b8.CAI = 1'b1;
        #1;
        chk("cao_fe", 32'(b8.CAO), 32'h0);
        step();
        chk("wrap_ff_q",   32'(b8.Q),   32'hFF);
        chk("wrap_ff_cao", 32'(b8.CAO), 32'h1);
        chk("wrap_ff_tcq", 32'(b8.TCQ), 32'h0);
        step();
        chk("wrap_0_q",   32'(b8.Q),   32'h0);
        chk("wrap_0_tcq", 32'(b8.TCQ), 32'h1);
        chk("wrap_0_cao", 32'(b8.CAO), 32'h0);
        step();
        chk("wrap_1_q",   32'(b8.Q),   32'h1);
        chk("wrap_1_tcq", 32'(b8.TCQ), 32'h0);

        // Carry suppressed without CAI; clear at terminal kills the strobe.
        b8.CAI = 1'b0; b8.LD = 1'b1; b8.D = 8'hFF;
        step();
        b8.LD = 1'b0;
        #1;
        chk("cao_no_cai", 32'(b8.CAO), 32'h0);
        b8.CAI = 1'b1; b8.SCLR = 1'b1;
        #1;
        chk("cao_term", 32'(b8.CAO), 32'h1);
        step();
        chk("sclr_term_q",   32'(b8.Q),   32'h0);
        chk("sclr_term_tcq", 32'(b8.TCQ), 32'h0);
        b8.CAI = 1'b0; b8.SCLR = 1'b0;

        // Modulo-10 sequence over 25 edges.
        b10.CAI = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 25; i++) begin
            #1;
            chk("m10_q",   32'(b10.Q),   32'(i % 10));
            chk("m10_cao", 32'(b10.CAO), 32'((i % 10) == 9));
            step();
            chk("m10_tcq", 32'(b10.TCQ), 32'((i % 10) == 9));
            if (b10.TCQ === 1'b1) pulses = pulses + 1;
        end
        chk("m10_final", 32'(b10.Q), 32'h5);
        chk("m10_pulses", 32'(pulses), 32'h2);

        // Priority: LD beats CAI at terminal, SCLR beats LD.
        b10.CAI = 1'b0; b10.LD = 1'b1; b10.D = 4'd9;
        step();
        b10.CAI = 1'b1; b10.D = 4'd3;
        #1;
        chk("prio_cao", 32'(b10.CAO), 32'h1);
        step();
        chk("prio_ld_q",   32'(b10.Q),   32'h3);
        chk("prio_ld_tcq", 32'(b10.TCQ), 32'h0);
        b10.SCLR = 1'b1;
        step();
        chk("prio_sclr_q", 32'(b10.Q), 32'h0);

        // Out-of-range load drops to 0 without a strobe.
        b10.SCLR = 1'b0; b10.CAI = 1'b0; b10.LD = 1'b1; b10.D = 4'd12;
        step();
        b10.LD = 1'b0; b10.CAI = 1'b1;
        #1;
        chk("oor_q",   32'(b10.Q),   32'hC);
        chk("oor_cao", 32'(b10.CAO), 32'h0);
        step();
        chk("oor_next_q",   32'(b10.Q),   32'h0);
        chk("oor_next_tcq", 32'(b10.TCQ), 32'h0);

        // Random control mix against the reference.
        mq = 0;
        for (int i = 0; i < 200; i++) begin
            rs = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 5) == 0);
            rc = ($urandom_range(0, 3) != 0);
            rd = int'($urandom_range(0, 15));
            b10.SCLR = rs; b10.LD = rl; b10.CAI = rc; b10.D = 4'(rd);
            #1;
            chk("rnd_cao", 32'(b10.CAO), 32'(rc && (mq == 9)));
            ref_next(mq, 10, rs, rl, rc, rd, mq_n, mtcq);
            step();
            mq = mq_n;
            chk("rnd_q",   32'(b10.Q),   32'(mq));
            chk("rnd_tcq", 32'(b10.TCQ), 32'(mtcq));
        end
        b10.SCLR = 1'b0; b10.LD = 1'b0; b10.CAI = 1'b0;

        // Two-stage cascade as a 16-bit count.
        blo.CAI = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            step();
            chk("cascade", {16'h0, bhi.Q, blo.Q}, 32'(n % 65536));
        end
        chk("cascade_300", {16'h0, bhi.Q, blo.Q}, 32'h012C);
        blo.CAI = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
